// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared Tomasulo types plus reservation-station dispatch records
package tomasulo_pkg;

  localparam int WORD_W       = 32;
  localparam int TAG_W        = 4;
  localparam int ROBID_W      = 4;
  localparam int IMM_W        = 16;
  localparam int RS_N_DEFAULT = 4;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [ROBID_W-1:0] robid_t;
  typedef logic [IMM_W-1:0]   imm_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV0, OP_MOV1, OP_MOVI
  } opcode_t;

  typedef struct packed {
    logic  vld;
    tag_t  tag;
    word_t wdata;
  } cdb_t;

  typedef struct packed {
    opcode_t     op;
    imm_t        imm;
    robid_t      robid;
    tag_t        tag;
    word_t [1:0] rdata;
  } issue_t;

  typedef struct packed {
    logic  rdy;
    tag_t  tag;
    word_t data;
  } rs_src_t;

  typedef struct packed {
    opcode_t       op;
    imm_t          imm;
    robid_t        robid;
    tag_t          tag;
    rs_src_t [1:0] src;
  } rs_disp_t;

  // A pending source captures the broadcast value when its producer tag matches.
  function automatic rs_src_t src_snoop(rs_src_t s, cdb_t c);
    rs_src_t r;
    r = s;
    if (!s.rdy && c.vld && (c.tag == s.tag)) begin
      r.rdy  = 1'b1;
      r.data = c.wdata;
    end
    return r;
  endfunction

endpackage

// File: rtl/tomasulo_rs_if.sv
// rtl/tomasulo_rs_if.sv - dispatch, broadcast and issue bundle of the reservation station
interface tomasulo_rs_if
  import tomasulo_pkg::*;
#(
  parameter int N = RS_N_DEFAULT
);
  logic                   disp_vld;
  rs_disp_t               disp;
  logic                   disp_rdy;
  cdb_t                   cdb_r;
  logic                   iss_vld;
  issue_t                 iss;
  logic [$clog2(N+1)-1:0] occ_r;

  modport master (
    output disp_vld, disp, cdb_r,
    input  disp_rdy, iss_vld, iss, occ_r
  );

  modport slave (
    input  disp_vld, disp, cdb_r,
    output disp_rdy, iss_vld, iss, occ_r
  );
endinterface

// File: rtl/tomasulo_rs_age_matrix.sv
// rtl/tomasulo_rs_age_matrix.sv - relative-age tracker granting the oldest requesting entry
module tomasulo_rs_age_matrix #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] alloc,
  input  logic [N-1:0] free,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  // older[i][j] set means entry i was allocated before entry j.
  logic [N-1:0] older [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (free[i] || free[j])
            older[i][j] <= 1'b0;
          else if (alloc[j] && (i != j))
            older[i][j] <= 1'b1;
          else if (alloc[i])
            older[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = req[i];
      for (int j = 0; j < N; j++) begin
        if (req[j] && older[j][i]) grant[i] = 1'b0;
      end
    end
  end
endmodule

// File: rtl/tomasulo_rs.sv
// rtl/tomasulo_rs.sv - reservation station: dispatch with CDB bypass, wakeup, oldest-ready issue
module tomasulo_rs
  import tomasulo_pkg::*;
#(
  parameter int N = RS_N_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  tomasulo_rs_if.slave rs
);
  localparam int OW = $clog2(N + 1);

  rs_disp_t        ent [N];
  logic [N-1:0]    vld;
  logic [N-1:0]    elig;
  logic [N-1:0]    grant;
  logic [N-1:0]    alloc;
  logic [OW-1:0]   occ;
  logic            accept;
  logic            sel;
  logic            found;
  rs_disp_t        disp_w;
  rs_disp_t        sel_ent;
  issue_t          iss_n;

  assign rs.occ_r    = occ;
  assign rs.disp_rdy = (occ != OW'(N));
  assign accept      = rs.disp_vld & rs.disp_rdy;
  assign sel         = |grant;

  always_comb begin
    alloc = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!vld[i] && !found) begin
        alloc[i] = accept;
        found    = 1'b1;
      end
    end
  end

  // Sources still pending at dispatch may be satisfied by this cycle's broadcast.
  always_comb begin
    disp_w = rs.disp;
    for (int s = 0; s < 2; s++) disp_w.src[s] = src_snoop(rs.disp.src[s], rs.cdb_r);
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      elig[i] = vld[i] & ent[i].src[0].rdy & ent[i].src[1].rdy;
  end

  tomasulo_rs_age_matrix #(.N(N)) u_age (
    .clk   (clk),
    .rst   (rst),
    .alloc (alloc),
    .free  (grant),
    .req   (elig),
    .grant (grant)
  );

  always_comb begin
    sel_ent = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) sel_ent = ent[i];
    end
    iss_n.op       = sel_ent.op;
    iss_n.imm      = sel_ent.imm;
    iss_n.robid    = sel_ent.robid;
    iss_n.tag      = sel_ent.tag;
    iss_n.rdata[0] = sel_ent.src[0].data;
    iss_n.rdata[1] = sel_ent.src[1].data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld        <= '0;
      occ        <= '0;
      rs.iss_vld <= 1'b0;
      rs.iss     <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (alloc[i])
          vld[i] <= 1'b1;
        else if (grant[i])
          vld[i] <= 1'b0;
      end
      occ        <= occ + OW'(accept) - OW'(sel);
      rs.iss_vld <= sel;
      if (sel) rs.iss <= iss_n;
    end
  end

  // Payload needs no reset; validity alone decides whether an entry exists.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (alloc[i]) begin
        ent[i] <= disp_w;
      end else if (vld[i]) begin
        for (int s = 0; s < 2; s++) ent[i].src[s] <= src_snoop(ent[i].src[s], rs.cdb_r);
      end
    end
  end
endmodule

// File: tb/tb_tomasulo_rs.sv
// tb/tb_tomasulo_rs.sv - scoreboard bench for tomasulo_rs against an age-ordered queue model
module tb_tomasulo_rs;
  import tomasulo_pkg::*;

  localparam int N  = 4;
  localparam int OW = $clog2(N + 1);

  typedef struct {
    issue_t iss;
    int     due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tomasulo_rs_if #(.N(N)) rs ();
  tomasulo_rs #(.N(N)) dut (.clk(clk), .rst(rst), .rs(rs));

  rs_disp_t mq [$];
  exp_t     exp_q [$];
  issue_t   hold = '0;
  int       cyc = 0;
  int       checks = 0;
  int       failures = 0;

  function automatic rs_disp_t mk(opcode_t op, int tag, int rob,
                                  bit r0, int t0, word_t d0,
                                  bit r1, int t1, word_t d1);
    rs_disp_t d;
    d.op          = op;
    d.imm         = imm_t'($urandom);
    d.robid       = robid_t'(rob);
    d.tag         = tag_t'(tag);
    d.src[0].rdy  = r0;
    d.src[0].tag  = tag_t'(t0);
    d.src[0].data = r0 ? d0 : word_t'($urandom);
    d.src[1].rdy  = r1;
    d.src[1].tag  = tag_t'(t1);
    d.src[1].data = r1 ? d1 : word_t'($urandom);
    return d;
  endfunction

  function automatic rs_disp_t capture(rs_disp_t d, cdb_t c);
    rs_disp_t r = d;
    if (c.vld) begin
      for (int s = 0; s < 2; s++) begin
        if (!r.src[s].rdy && r.src[s].tag == c.tag) begin
          r.src[s].rdy  = 1'b1;
          r.src[s].data = c.wdata;
        end
      end
    end
    return r;
  endfunction

  // Model: entries kept in arrival order; the first fully-ready one leaves each clock.
  task automatic model_step();
    bit   room;
    int   pick;
    exp_t x;
    if (rst) begin
      mq.delete();
      hold = '0;
      cyc++;
      return;
    end
    room = (mq.size() != N);
    pick = -1;
    for (int k = 0; k < mq.size(); k++)
      if (pick < 0 && mq[k].src[0].rdy && mq[k].src[1].rdy) pick = k;
    if (pick >= 0) begin
      x.iss.op       = mq[pick].op;
      x.iss.imm      = mq[pick].imm;
      x.iss.robid    = mq[pick].robid;
      x.iss.tag      = mq[pick].tag;
      x.iss.rdata[0] = mq[pick].src[0].data;
      x.iss.rdata[1] = mq[pick].src[1].data;
      x.due          = cyc + 1;
      exp_q.push_back(x);
      hold = x.iss;
      mq.delete(pick);
    end
    for (int k = 0; k < mq.size(); k++) mq[k] = capture(mq[k], rs.cdb_r);
    if (rs.disp_vld && room) mq.push_back(capture(rs.disp, rs.cdb_r));
    cyc++;
  endtask

  task automatic tick();
    if (rs.disp_vld && !rst) begin
      checks++;
      if (!rs.disp_rdy) begin
        failures++;
        $display("FAIL illegal_dispatch disp_rdy=%0b required=1 cyc=%0d", rs.disp_rdy, cyc);
      end
    end
    @(posedge clk);
    model_step();
    #1;
    rst         = 1'b0;
    rs.disp_vld = 1'b0;
    rs.cdb_r    = '0;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic dispatch(rs_disp_t d);
    rs.disp_vld = 1'b1;
    rs.disp     = d;
  endtask

  task automatic bcast(int tag, word_t data);
    rs.cdb_r.vld   = 1'b1;
    rs.cdb_r.tag   = tag_t'(tag);
    rs.cdb_r.wdata = data;
  endtask

  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      checks++;
      if (rs.occ_r !== OW'(mq.size())) begin
        failures++;
        $display("FAIL occ_r got=%0d exp=%0d cyc=%0d", rs.occ_r, mq.size(), cyc);
      end
      checks++;
      if (rs.disp_rdy !== (mq.size() != N)) begin
        failures++;
        $display("FAIL disp_rdy got=%0b exp=%0b cyc=%0d", rs.disp_rdy, mq.size() != N, cyc);
      end
      checks++;
      if (rs.iss_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_issue got=%h exp=none cyc=%0d", rs.iss, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.due != cyc || rs.iss !== e.iss) begin
            failures++;
            $display("FAIL issue got=%h@%0d exp=%h@%0d", rs.iss, cyc, e.iss, e.due);
          end
        end
      end else begin
        if (rs.iss_vld !== 1'b0 || (exp_q.size() > 0 && exp_q[0].due <= cyc)) begin
          failures++;
          $display("FAIL missing_issue iss_vld=%b exp=1 cyc=%0d", rs.iss_vld, cyc);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        checks++;
        if (rs.iss !== hold) begin
          failures++;
          $display("FAIL iss_hold got=%h exp=%h cyc=%0d", rs.iss, hold, cyc);
        end
      end
    end
  end

  initial begin
    rs.disp_vld = 1'b0;
    rs.disp     = '0;
    rs.cdb_r    = '0;
    rst = 1'b1; tick();
    rst = 1'b1; tick();
    idle(3);

    // both sources ready: issue two cycles after dispatch
    dispatch(mk(OP_AND, 5, 2, 1, 0, 32'hF0, 1, 0, 32'h3C)); tick();
    idle(4);

    // wakeup on matching tag only
    dispatch(mk(OP_ADD, 6, 3, 0, 3, 0, 1, 0, 32'h11)); tick();
    idle(3);
    bcast(4, 32'hBB); tick();
    idle(2);
    bcast(3, 32'hAA); tick();
    idle(3);

    // broadcast during the dispatch cycle
    dispatch(mk(OP_OR, 8, 4, 1, 0, 32'h12, 0, 7, 0));
    bcast(7, 32'h55); tick();
    idle(3);

    // oldest-first with a late-waking elder
    dispatch(mk(OP_SUB, 1, 5, 0, 1, 0, 1, 0, 32'h1)); tick();
    dispatch(mk(OP_XOR, 2, 6, 1, 0, 32'h2, 1, 0, 32'h3)); tick();
    dispatch(mk(OP_NOT, 3, 7, 1, 0, 32'h4, 1, 0, 32'h5)); tick();
    idle(4);
    bcast(1, 32'h77); tick();
    idle(3);
    for (int k = 0; k < 3; k++) begin
      dispatch(mk(OP_MOV0, 10 + k, k, 0, 2, 0, 1, 0, 32'h9)); tick();
    end
    bcast(2, 32'h22); tick();
    idle(5);

    // fill, then free one and refill
    for (int k = 0; k < N; k++) begin
      dispatch(mk(OP_MOV1, k, 8 + k, 1, 0, 32'h30 + k, 0, 9, 0)); tick();
    end
    idle(2);
    bcast(9, 32'h99); tick();
    tick();
    dispatch(mk(OP_MOVI, 14, 12, 1, 0, 32'h44, 1, 0, 32'h45)); tick();
    idle(8);

    // reset with entries held and an issue about to happen
    for (int k = 0; k < 3; k++) begin
      dispatch(mk(OP_ADD, k, k, 0, 11, 0, 0, 12, 0)); tick();
    end
    dispatch(mk(OP_AND, 13, 13, 1, 0, 32'h5, 1, 0, 32'h6)); tick();
    rst = 1'b1; tick();
    bcast(11, 32'h1); tick();
    bcast(12, 32'h2); tick();
    idle(4);

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      if (mq.size() != N && $urandom_range(0, 99) < 60)
        dispatch(mk(opcode_t'($urandom_range(0, 8)), $urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                    $urandom_range(0, 1), $urandom_range(0, 7), $urandom));
      if ($urandom_range(0, 99) < 40) bcast($urandom_range(0, 7), $urandom);
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      tick();
    end

    // drain with bounded wait
    for (int c = 0; c < 300 && mq.size() != 0; c++) begin
      bcast(c % 8, $urandom);
      tick();
    end
    idle(4);
    checks++;
    if (mq.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout held=%0d pending=%0d exp=0", mq.size(), exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tomasulo_rs.md
Name: tomasulo_rs

Overview:
- Reservation station sitting directly upstream of the execute logic.
- Accepts dispatched ops whose sources are either values or pending producer tags, and snoops the registered CDB to capture late operands.
- Each cycle, issues the oldest ready entry as a registered issue_t/iss_vld pair into the execute unit.
- The execute unit has no back-pressure, so the station issues at most one op per cycle.

Parameters:
N, 4, number of station entries (2..16)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
disp_vld  input  1  dispatch request
disp  input  tomasulo_pkg::rs_disp_t  op, imm, robid, dest tag, src[1:0]{rdy,tag,data}
disp_rdy  output  1  station can accept a dispatch this cycle
cdb_r  input  tomasulo_pkg::cdb_t  registered completion broadcast
iss_vld  output  1  issue valid (registered)
iss  output  tomasulo_pkg::issue_t  op, imm, robid, tag, rdata[1:0] (registered)
occ_r  output  $clog2(N+1)  current number of valid entries

Behaviour:
- Interface is fixed: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - all entry valid bits 0, occ_r=0;
  - iss_vld=0 and iss='0;
  - disp_rdy=1 in the first cycle after reset; age matrix cleared.
- disp_rdy = (occ_r != N). It is combinational from registered state only. An entry freed in cycle t is not reusable by a dispatch in cycle t.
- Dispatch handshake: the transfer occurs when disp_vld & disp_rdy.
  - Writes the lowest-index free entry at the clock edge.
  - disp_vld & !disp_rdy is illegal; the bench asserts on it and the RTL ignores the request.
- Dispatch/CDB bypass:
  - In the dispatch cycle, each src with rdy=0 is compared against cdb_r.
  - If cdb_r.vld and the tags match, the entry stores rdy=1 with data=cdb_r.wdata.
  - A broadcast in the dispatch cycle must never be missed.
- Wakeup: for every valid entry src with rdy=0, a match with cdb_r.vld and tag captures wdata and sets rdy at the next edge. Both srcs may wake on the same broadcast.
- Unused sources (NOT, MOV0/MOV1 other operand, MOVI) are dispatched with rdy=1; the station does not decode op.
- Select and issue:
  - Eligible entries are valid with both src rdy in registered state. Wakeup in cycle t makes the entry eligible at t+1.
  - Oldest eligible entry wins via the age matrix.
  - On select in cycle t: the entry is cleared at the edge, and iss/iss_vld are loaded at the same edge and valid during t+1.
  - With no eligible entry: iss_vld=0 and iss holds its previous value.
- Minimum latency: dispatch with both srcs ready in cycle t → iss_vld in t+2. Src woken by cdb_r in cycle t → iss_vld earliest t+2.
- occ_r update: occ_r += dispatch − select. Simultaneous dispatch and select leaves occ_r unchanged.
- Age matrix: a new entry is marked younger than all currently valid entries. Freeing clears its row and column.
- Full: occ_r==N → disp_rdy=0. Select still proceeds, and disp_rdy returns to 1 the following cycle.
- Empty: no issue, and cdb_r traffic is ignored.
- Reset mid-operation drops all entries. In-flight execute results are not this block's concern.

Decomposition:
- tomasulo_pkg additions:
  - rs_src_t {rdy, tag_t tag, word_t data};
  - rs_disp_t {opcode_t op, imm_t imm, robid_t robid, tag_t tag, rs_src_t [1:0] src};
  - RS_N_DEFAULT constant.
- Existing issue_t, cdb_t, tag_t and word_t are reused unchanged.
- Sub-module tomasulo_rs_age_matrix #(N):
  - inputs: alloc one-hot, free one-hot, req vector;
  - output: one-hot grant of the oldest requester;
  - N×N flopped matrix, synchronous active-high reset.

Test Plan:
- Ready dispatch: op=OP_AND, src0=0xF0, src1=0x3C both rdy, tag=5, robid=2 at cycle 10 → iss_vld=1 at cycle 12 with iss.rdata={0x3C,0xF0}, tag=5, robid=2; occ_r 0→1→0.
- Wakeup: dispatch src0 pending tag=3 → no issue. cdb_r{vld=1,tag=3,wdata=0xAA} at cycle 20 → iss_vld at 22 with rdata[0]=0xAA. A cdb with tag=4 causes no wakeup.
- Dispatch/CDB collision: dispatch src1 pending tag=7 in the same cycle cdb_r{vld,tag=7,wdata=0x55} → issue 2 cycles later with rdata[1]=0x55, no hang.
- Oldest-first:
  - dispatch A (pending tag 1), then B, C ready; → B issues, then C.
  - then broadcast tag 1 → A issues.
  - With all three ready simultaneously, the order is strictly A, B, C.
- Full/back-pressure: with N=4, dispatch 4 pending entries → disp_rdy=0, occ_r=4. Broadcast the waking tag → one select, disp_rdy=1 next cycle, new dispatch accepted into the freed lowest index.
- Reset mid-flight: 3 valid entries and a pending issue; assert rst one cycle → iss_vld=0, occ_r=0, disp_rdy=1. Stale cdb_r tags cause no issue afterward.
